// File: rtl/topk_sort_ctrl.sv
// topk_sort_ctrl: job sequencer for the 5-entry top-k merge sorter chain.
// Optional abort input is enabled by defining TOPK_CTRL_ABORT_EN.
module topk_sort_ctrl #(
  parameter int CNT_W    = 16,
  parameter int SORT_GAP = 7,
  parameter int CLR_CYC  = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_chunks,
  input  logic             chunk_vld,
  output logic             chunk_rdy,
  output logic [CNT_W-1:0] chunk_idx,
  output logic             sorter_clr,
  output logic             sort_en,
  output logic             last_sort,
  input  logic             sorter_valid,
  input  logic             last_sort_o,
`ifdef TOPK_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             err_seq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_WAIT,
    S_GAP,
    S_DRAIN,
    S_FIN,
    S_ABRT
  } state_t;

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [7:0]       GAP_LD = 8'(SORT_GAP - 1);
  localparam logic [3:0]       CLR_LD = 4'(CLR_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_rsp;
  logic [7:0]       r_gap;
  logic [3:0]       r_clr_cnt;
  logic             r_last_seen;
  logic             r_chunk_rdy;
  logic             r_sorter_clr;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic w_abort;
  logic w_accept;
  logic w_final_idx;
  logic w_more;
  logic w_outst;
  logic w_track;
  logic w_rsp_final;
  logic w_err;
  logic w_last_hit;

`ifdef TOPK_CTRL_ABORT_EN
  assign w_abort = abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Zero-cycle handshake: a staged chunk is taken in the WAIT cycle itself.
  assign w_accept    = (r_state == S_WAIT) & chunk_vld & ~w_abort;
  assign w_final_idx = (r_idx == r_num - ONE);
  assign w_more      = (r_idx != r_num);
  // Responses outstanding = issued pulses not yet answered.
  assign w_outst     = (r_idx != r_rsp);
  assign w_track     = (r_state != S_IDLE) & (r_state != S_ABRT);
  assign w_rsp_final = (r_rsp == r_num - ONE);
  assign w_err       = w_track & sorter_valid &
                       (~w_outst | (last_sort_o & ~w_rsp_final));
  assign w_last_hit  = w_track & sorter_valid & w_outst &
                       last_sort_o & w_rsp_final;

  assign chunk_rdy  = r_chunk_rdy;
  assign chunk_idx  = r_idx;
  assign sorter_clr = r_sorter_clr;
  assign sort_en    = w_accept;
  assign last_sort  = w_accept & w_final_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err_seq    = r_err;

  // Job FSM with response tracking and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_idx        <= '0;
      r_rsp        <= '0;
      r_gap        <= '0;
      r_clr_cnt    <= '0;
      r_last_seen  <= 1'b0;
      r_chunk_rdy  <= 1'b0;
      r_sorter_clr <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      if (w_track && sorter_valid && w_outst) begin
        r_rsp <= r_rsp + ONE;
      end
      if (w_last_hit) begin
        r_last_seen <= 1'b1;
      end
      if (w_err) begin
        r_err <= 1'b1;
      end
      if (w_abort) begin
        r_state      <= S_ABRT;
        r_sorter_clr <= 1'b1;
        r_chunk_rdy  <= 1'b0;
        r_done       <= 1'b0;
        r_clr_cnt    <= CLR_LD;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state      <= S_CLR;
              r_num        <= num_chunks;
              r_busy       <= 1'b1;
              r_err        <= 1'b0;
              r_sorter_clr <= 1'b1;
              r_clr_cnt    <= CLR_LD;
              r_idx        <= '0;
              r_rsp        <= '0;
              r_last_seen  <= 1'b0;
            end
          end
          S_CLR: begin
            if (r_clr_cnt == 4'd0) begin
              r_sorter_clr <= 1'b0;
              if (r_num == '0) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_WAIT;
                r_chunk_rdy <= 1'b1;
              end
            end else begin
              r_clr_cnt <= r_clr_cnt - 4'd1;
            end
          end
          S_WAIT: begin
            if (chunk_vld) begin
              r_idx       <= r_idx + ONE;
              r_chunk_rdy <= 1'b0;
              r_gap       <= GAP_LD;
              r_state     <= S_GAP;
            end
          end
          S_GAP: begin
            r_gap <= r_gap - 8'd1;
            if (r_gap == 8'd1) begin
              if (w_more) begin
                r_state     <= S_WAIT;
                r_chunk_rdy <= 1'b1;
              end else begin
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (r_last_seen || w_last_hit) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
          S_FIN: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          S_ABRT: begin
            if (r_clr_cnt == 4'd0) begin
              r_sorter_clr <= 1'b0;
              r_busy       <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt - 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
